// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit stack CPU: imem geometry and the boot sequencer state encoding.
package cpu_pkg;

  localparam int BOOT_ADDR_W = 10;
  localparam int BOOT_DATA_W = 16;

  typedef enum logic [3:0] {
    ST_CNT_LO  = 4'd0,
    ST_CNT_HI  = 4'd1,
    ST_WORD_LO = 4'd2,
    ST_WORD_HI = 4'd3,
    ST_WRITE   = 4'd4,
    ST_SUM_LO  = 4'd5,
    ST_SUM_HI  = 4'd6,
    ST_RELEASE = 4'd7,
    ST_RUN     = 4'd8,
    ST_ERROR   = 4'd9
  } boot_state_t;

  // States in which the sequencer consumes bytes from the receiver.
  function automatic logic boot_accepts_bytes(input boot_state_t s);
    return (s == ST_CNT_LO)  || (s == ST_CNT_HI)  ||
           (s == ST_WORD_LO) || (s == ST_WORD_HI) ||
           (s == ST_SUM_LO)  || (s == ST_SUM_HI);
  endfunction

endpackage

// File: rtl/boot_byte_pair.sv
// Lo/hi byte assembler: the second byte of each pair completes a 16-bit word (word_valid_o pulse).
module boot_byte_pair (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] word_o,
  output logic        word_valid_o
);

  logic       hi_q, hi_d;
  logic [7:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (clear_i) begin
      hi_d = 1'b0;
    end else if (byte_valid_i) begin
      if (!hi_q) lo_d = byte_i;
      hi_d = ~hi_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 1'b0;
      lo_q <= 8'h00;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // The word is presented combinationally so the FSM can act in the hi-byte transfer cycle.
  assign word_o       = {byte_i, lo_q};
  assign word_valid_o = byte_valid_i & hi_q & ~clear_i;

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer: holds the CPU in reset, streams an image from the byte receiver into imem, then releases it.
// Optional trailing checksum check is enabled by defining CPU_BOOT_CHECKSUM_EN.
module cpu_boot_ctrl
  import cpu_pkg::*;
#(
  parameter int          ADDR_W      = BOOT_ADDR_W,
  parameter int          DATA_W      = BOOT_DATA_W,
  parameter int unsigned START_ADDR  = 0,
  parameter int          RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              imem_we,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_err
);

  boot_state_t       state_q, state_d;
  logic              rdy_en_q;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [15:0]       remain_q, remain_d;
  logic [3:0]        dly_q, dly_d;
  logic [15:0]       pair_word;
  logic              pair_valid;
  logic              xfer;
`ifdef CPU_BOOT_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  assign rx_ready = rdy_en_q & boot_accepts_bytes(state_q);
  assign xfer     = rx_valid & rx_ready;

  boot_byte_pair u_pair (
    .clk          (clk),
    .rst_n        (reset),
    .clear_i      (reload),
    .byte_valid_i (xfer),
    .byte_i       (rx_data),
    .word_o       (pair_word),
    .word_valid_o (pair_valid)
  );

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    remain_d = remain_q;
    dly_d    = dly_q;
`ifdef CPU_BOOT_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    if (reload) begin
      state_d  = ST_CNT_LO;
      waddr_d  = ADDR_W'(START_ADDR);
      remain_d = 16'd0;
      dly_d    = 4'd0;
`ifdef CPU_BOOT_CHECKSUM_EN
      sum_d    = 16'd0;
`endif
    end else begin
      case (state_q)
        ST_CNT_LO:  if (xfer) state_d = ST_CNT_HI;
        ST_CNT_HI: begin
          if (pair_valid) begin
            remain_d = pair_word;
            dly_d    = 4'd0;
`ifdef CPU_BOOT_CHECKSUM_EN
            state_d  = (pair_word == 16'd0) ? ST_SUM_LO : ST_WORD_LO;
`else
            state_d  = (pair_word == 16'd0) ? ST_RELEASE : ST_WORD_LO;
`endif
          end
        end
        ST_WORD_LO: if (xfer) state_d = ST_WORD_HI;
        ST_WORD_HI: begin
          if (pair_valid) begin
            wdata_d = DATA_W'(pair_word);
            state_d = ST_WRITE;
          end
        end
        // Address wraps naturally at 2^ADDR_W, so oversized images overwrite from the start.
        ST_WRITE: begin
          waddr_d  = waddr_q + 1'b1;
          remain_d = remain_q - 16'd1;
          dly_d    = 4'd0;
`ifdef CPU_BOOT_CHECKSUM_EN
          sum_d    = sum_q + 16'(wdata_q);
          state_d  = (remain_q == 16'd1) ? ST_SUM_LO : ST_WORD_LO;
`else
          state_d  = (remain_q == 16'd1) ? ST_RELEASE : ST_WORD_LO;
`endif
        end
`ifdef CPU_BOOT_CHECKSUM_EN
        ST_SUM_LO:  if (xfer) state_d = ST_SUM_HI;
        ST_SUM_HI: begin
          if (pair_valid) state_d = (pair_word == sum_q) ? ST_RELEASE : ST_ERROR;
        end
`endif
        ST_RELEASE: begin
          if (dly_q == 4'(RELEASE_DLY - 1)) state_d = ST_RUN;
          else                              dly_d   = dly_q + 4'd1;
        end
        ST_RUN, ST_ERROR: state_d = state_q;
        default:          state_d = ST_CNT_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_CNT_LO;
      rdy_en_q <= 1'b0;
      waddr_q  <= ADDR_W'(START_ADDR);
      wdata_q  <= '0;
      remain_q <= 16'd0;
      dly_q    <= 4'd0;
`ifdef CPU_BOOT_CHECKSUM_EN
      sum_q    <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      remain_q <= remain_d;
      dly_q    <= dly_d;
`ifdef CPU_BOOT_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign imem_we    = (state_q == ST_WRITE);
  assign cpu_reset  = (state_q != ST_RUN);
  assign boot_done  = (state_q == ST_RUN);
`ifdef CPU_BOOT_CHECKSUM_EN
  assign boot_err   = (state_q == ST_ERROR);
`else
  assign boot_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Self-checking bench for cpu_boot_ctrl: cycle table for a full load plus directed multi-cycle sequences.
module tb_cpu_boot_ctrl;

  localparam int RELEASE_DLY = 4;

  logic        clk = 1'b0;
  logic        resetN;
  logic        reload;
  logic        rxValid;
  logic [7:0]  rxData;
  logic        rxReady;
  logic [9:0]  imemWaddr;
  logic [15:0] imemWdata;
  logic        imemWe;
  logic        cpuReset;
  logic        bootDone;
  logic        bootErr;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t wrLog[$];

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic        cpuRst;
    logic        done;
  } vec_t;
  vec_t vecs[$];

  logic [15:0] imgWords[$];

  always #5 clk = ~clk;

  cpu_boot_ctrl #(
    .ADDR_W      (10),
    .DATA_W      (16),
    .START_ADDR  (0),
    .RELEASE_DLY (RELEASE_DLY)
  ) dut (
    .clk        (clk),
    .reset      (resetN),
    .reload     (reload),
    .rx_valid   (rxValid),
    .rx_data    (rxData),
    .rx_ready   (rxReady),
    .imem_waddr (imemWaddr),
    .imem_wdata (imemWdata),
    .imem_we    (imemWe),
    .cpu_reset  (cpuReset),
    .boot_done  (bootDone),
    .boot_err   (bootErr)
  );

  // Record every imem write as seen mid-cycle.
  always @(negedge clk) begin
    if (imemWe) wrLog.push_back('{imemWaddr, imemWdata});
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic addVec(input logic valid, input logic [7:0] data, input logic rdy, input logic we,
                        input logic [9:0] addr, input logic [15:0] wdata, input logic cpuRst,
                        input logic done);
    vec_t v;
    v.valid = valid; v.data = data; v.rdy = rdy; v.we = we;
    v.addr = addr; v.wdata = wdata; v.cpuRst = cpuRst; v.done = done;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    rxValid = v.valid;
    rxData  = v.data;
    #1;
    checkOutput($sformatf("vec%0d rx_ready", idx), 32'(rxReady), 32'(v.rdy));
    checkOutput($sformatf("vec%0d imem_we", idx), 32'(imemWe), 32'(v.we));
    checkOutput($sformatf("vec%0d cpu_reset", idx), 32'(cpuReset), 32'(v.cpuRst));
    checkOutput($sformatf("vec%0d boot_done", idx), 32'(bootDone), 32'(v.done));
    checkOutput($sformatf("vec%0d boot_err", idx), 32'(bootErr), 32'd0);
    if (v.we) begin
      checkOutput($sformatf("vec%0d imem_waddr", idx), 32'(imemWaddr), 32'(v.addr));
      checkOutput($sformatf("vec%0d imem_wdata", idx), 32'(imemWdata), 32'(v.wdata));
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    int n;
    rxValid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rxValid = 1'b1;
    rxData  = b;
    #1;
    n = 0;
    while (!rxReady && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checkOutput("rx_ready timeout", 32'd0, 32'd1);
      rxValid = 1'b0;
    end else begin
      @(negedge clk);
      rxValid = 1'b0;
    end
  endtask

  task automatic sendHeaderAndWords(input int gap);
    logic [15:0] n;
    n = 16'(imgWords.size());
    sendByte(n[7:0], gap);
    sendByte(n[15:8], gap);
    foreach (imgWords[i]) begin
      sendByte(imgWords[i][7:0], gap);
      sendByte(imgWords[i][15:8], gap);
    end
  endtask

`ifdef CPU_BOOT_CHECKSUM_EN
  task automatic sendChecksum(input logic [15:0] s, input int gap);
    sendByte(s[7:0], gap);
    sendByte(s[15:8], gap);
  endtask

  function automatic logic [15:0] imageSum();
    logic [15:0] s;
    s = 16'd0;
    foreach (imgWords[i]) s = s + imgWords[i];
    return s;
  endfunction
`endif

  task automatic sendImage(input int gap);
    sendHeaderAndWords(gap);
`ifdef CPU_BOOT_CHECKSUM_EN
    sendChecksum(imageSum(), gap);
`endif
  endtask

  task automatic waitDone(input string name, input int maxCycles);
    int n;
    n = 0;
    #1;
    while (!bootDone && n < maxCycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(name, 32'(bootDone), 32'd1);
  endtask

  task automatic pulseReload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    #1;
    checkOutput("reload cpu_reset", 32'(cpuReset), 32'd1);
    checkOutput("reload boot_done", 32'(bootDone), 32'd0);
    checkOutput("reload waddr", 32'(imemWaddr), 32'd0);
  endtask

  initial begin
    int cnt;
    resetN  = 1'b0;
    reload  = 1'b0;
    rxValid = 1'b0;
    rxData  = 8'h00;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset cpu_reset", 32'(cpuReset), 32'd1);
    checkOutput("reset rx_ready", 32'(rxReady), 32'd0);
    checkOutput("reset imem_we", 32'(imemWe), 32'd0);
    checkOutput("reset waddr", 32'(imemWaddr), 32'd0);
    checkOutput("reset wdata", 32'(imemWdata), 32'd0);
    checkOutput("reset boot_done", 32'(bootDone), 32'd0);
    checkOutput("reset boot_err", 32'(bootErr), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    checkOutput("post-reset rx_ready before clk", 32'(rxReady), 32'd0);

    // Test 1: N=3 image, cycle by cycle
    addVec(1, 8'h03, 1, 0, 10'd0, 16'h0000, 1, 0);
    addVec(1, 8'h00, 1, 0, 10'd0, 16'h0000, 1, 0);
    addVec(1, 8'h01, 1, 0, 10'd0, 16'h0000, 1, 0);
    addVec(1, 8'h80, 1, 0, 10'd0, 16'h0000, 1, 0);
    addVec(0, 8'h00, 0, 1, 10'd0, 16'h8001, 1, 0);
    addVec(1, 8'h02, 1, 0, 10'd0, 16'h0000, 1, 0);
    addVec(1, 8'h80, 1, 0, 10'd0, 16'h0000, 1, 0);
    addVec(0, 8'h00, 0, 1, 10'd1, 16'h8002, 1, 0);
    addVec(1, 8'h07, 1, 0, 10'd0, 16'h0000, 1, 0);
    addVec(1, 8'hE0, 1, 0, 10'd0, 16'h0000, 1, 0);
    addVec(0, 8'h00, 0, 1, 10'd2, 16'hE007, 1, 0);
`ifdef CPU_BOOT_CHECKSUM_EN
    addVec(1, 8'h0A, 1, 0, 10'd0, 16'h0000, 1, 0);
    addVec(1, 8'hE0, 1, 0, 10'd0, 16'h0000, 1, 0);
`endif
    for (int i = 0; i < RELEASE_DLY; i++) addVec(0, 8'h00, 0, 0, 10'd0, 16'h0000, 1, 0);
    addVec(1, 8'h55, 0, 0, 10'd0, 16'h0000, 0, 1);
    addVec(1, 8'h55, 0, 0, 10'd0, 16'h0000, 0, 1);
    foreach (vecs[i]) applyStimulus(vecs[i], i);
    rxValid = 1'b0;

    // Test 2: empty image
    pulseReload();
    wrLog.delete();
    imgWords.delete();
    sendImage(0);
    cnt = 0;
    while (cpuReset && cnt < 50) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    checkOutput("N=0 release delay", 32'(cnt), 32'(RELEASE_DLY));
    checkOutput("N=0 writes", 32'(wrLog.size()), 32'd0);
    checkOutput("N=0 boot_done", 32'(bootDone), 32'd1);

    // Test 3: sparse rx_valid
    pulseReload();
    wrLog.delete();
    imgWords = '{16'h1234};
    sendImage(2);
    waitDone("sparse boot_done", 50);
    checkOutput("sparse writes", 32'(wrLog.size()), 32'd1);
    if (wrLog.size() == 1) begin
      checkOutput("sparse addr", 32'(wrLog[0].addr), 32'd0);
      checkOutput("sparse data", 32'(wrLog[0].data), 32'h1234);
    end

    // Test 4: reload mid-image, then reload coinciding with a byte transfer
    pulseReload();
    wrLog.delete();
    sendByte(8'h05, 0);
    sendByte(8'h00, 0);
    sendByte(8'h01, 0); sendByte(8'hA0, 0);
    sendByte(8'h02, 0); sendByte(8'hA0, 0);
    @(negedge clk);
    checkOutput("partial writes", 32'(wrLog.size()), 32'd2);
    pulseReload();
    @(negedge clk);
    reload  = 1'b1;
    rxValid = 1'b1;
    rxData  = 8'h07;
    @(negedge clk);
    reload  = 1'b0;
    rxValid = 1'b0;
    wrLog.delete();
    imgWords = '{16'hB001, 16'hB002};
    sendImage(0);
    waitDone("restart boot_done", 50);
    checkOutput("restart writes", 32'(wrLog.size()), 32'd2);
    if (wrLog.size() == 2) begin
      checkOutput("restart addr0", 32'(wrLog[0].addr), 32'd0);
      checkOutput("restart data0", 32'(wrLog[0].data), 32'hB001);
      checkOutput("restart addr1", 32'(wrLog[1].addr), 32'd1);
      checkOutput("restart data1", 32'(wrLog[1].data), 32'hB002);
    end

    // Test 5: N=1025 wraps the address
    pulseReload();
    wrLog.delete();
    imgWords.delete();
    for (int i = 0; i < 1025; i++) imgWords.push_back(16'h4000 + 16'(i));
    sendImage(0);
    waitDone("wrap boot_done", 50);
    checkOutput("wrap writes", 32'(wrLog.size()), 32'd1025);
    if (wrLog.size() == 1025) begin
      checkOutput("wrap addr1023", 32'(wrLog[1023].addr), 32'd1023);
      checkOutput("wrap data1023", 32'(wrLog[1023].data), 32'h43FF);
      checkOutput("wrap addr1024", 32'(wrLog[1024].addr), 32'd0);
      checkOutput("wrap data1024", 32'(wrLog[1024].data), 32'h4400);
    end

    // Async reset in the middle of a load
    pulseReload();
    sendByte(8'h03, 0);
    sendByte(8'h00, 0);
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("async cpu_reset", 32'(cpuReset), 32'd1);
    checkOutput("async rx_ready", 32'(rxReady), 32'd0);
    checkOutput("async waddr", 32'(imemWaddr), 32'd0);
    checkOutput("async imem_we", 32'(imemWe), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    checkOutput("async release rx_ready", 32'(rxReady), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("async first clk rx_ready", 32'(rxReady), 32'd1);

`ifdef CPU_BOOT_CHECKSUM_EN
    // Test 6: checksum match and mismatch
    pulseReload();
    imgWords = '{16'h1234, 16'h5678};
    sendHeaderAndWords(0);
    sendChecksum(16'h68AC, 0);
    waitDone("sum ok boot_done", 50);
    checkOutput("sum ok boot_err", 32'(bootErr), 32'd0);
    pulseReload();
    sendHeaderAndWords(0);
    sendChecksum(16'h68AD, 0);
    repeat (RELEASE_DLY + 3) @(negedge clk);
    #1;
    checkOutput("sum bad boot_err", 32'(bootErr), 32'd1);
    checkOutput("sum bad cpu_reset", 32'(cpuReset), 32'd1);
    checkOutput("sum bad boot_done", 32'(bootDone), 32'd0);
    pulseReload();
    checkOutput("sum bad cleared", 32'(bootErr), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
